// File: rtl/basket_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | basket_controller: basket quantity table with a running price total,     |
// | refreshed by a sequential summing pass after each add/remove request.    |
// | Optional feature macro: BASKET_PENDING_EN (one-deep pending request).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module basket_controller #(
  parameter int NUM_PRODUCTS = 12,
  parameter int QTY_W        = 8,
  parameter int PRICE_BASE   = 5,
  parameter int PRICE_STEP   = 5,
  parameter int TOTAL_W      = 20
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               ENABLE,
  input  logic [3:0]         ProductID_in,
  input  logic [3:0]         ProductQuantity_in,
  input  logic               Remove_in,
  input  logic               CLEAR,
  input  logic [3:0]         RD_ADDR,
  output logic [QTY_W-1:0]   RD_QTY,
  output logic [TOTAL_W-1:0] Total_out,
  output logic [3:0]         ItemCount_out,
  output logic               Busy,
  output logic               Done_Pulse,
  output logic               Invalid_Flag,
  output logic               Drop_Flag
);

  localparam int     c_last_idx  = NUM_PRODUCTS - 1;
  localparam int     c_max_price = PRICE_BASE + c_last_idx * PRICE_STEP;
  localparam longint c_max_total = longint'(NUM_PRODUCTS) * longint'((1 << QTY_W) - 1)
                                   * longint'(c_max_price);

  if (c_max_total >= (longint'(1) << TOTAL_W)) begin : g_total_w_check
    $error("basket_controller: TOTAL_W too narrow for the maximum basket total");
  end
  if (NUM_PRODUCTS > 16 || QTY_W < 4) begin : g_shape_check
    $error("basket_controller: NUM_PRODUCTS must be <= 16 and QTY_W >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_SUM    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state, w_state_next;
  logic [QTY_W-1:0]   r_qty [NUM_PRODUCTS];
  logic [3:0]         r_req_id, r_req_qty;
  logic               r_req_remove;
  logic [3:0]         r_idx;
  logic [TOTAL_W-1:0] r_acc;
  logic [3:0]         r_cnt;

  logic               w_enable, w_last, w_load_in, w_drop, w_req_valid;
  logic [QTY_W-1:0]   w_cur_qty, w_tgt_qty, w_new_qty;
  logic [QTY_W:0]     w_sum_ext;
  logic [TOTAL_W-1:0] w_price, w_acc_next;
  logic [3:0]         w_cnt_next;
`ifdef BASKET_PENDING_EN
  logic               r_pend_valid, r_pend_remove;
  logic [3:0]         r_pend_id, r_pend_qty;
  logic               w_load_pend, w_capture;
`endif

  // A request coinciding with CLEAR is simply discarded, never counted as dropped.
  assign w_enable = ENABLE & ~CLEAR;
  assign w_last   = (r_idx == 4'(c_last_idx));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    Busy         = (r_state != S_IDLE);
    Done_Pulse   = (r_state == S_DONE);
    w_load_in    = 1'b0;
    w_drop       = 1'b0;
`ifdef BASKET_PENDING_EN
    w_load_pend  = 1'b0;
    w_capture    = 1'b0;
`endif
    case (r_state)
      S_IDLE:   if (w_enable) begin
                  w_state_next = S_UPDATE;
                  w_load_in    = 1'b1;
                end
      S_UPDATE: w_state_next = S_SUM;
      S_SUM:    if (w_last) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
`ifdef BASKET_PENDING_EN
    // Leaving DONE chains straight into the next request, so Busy never drops.
    if (r_state == S_DONE) begin
      if (r_pend_valid) begin
        w_state_next = S_UPDATE;
        w_load_pend  = 1'b1;
        w_drop       = w_enable;
      end else if (w_enable) begin
        w_state_next = S_UPDATE;
        w_load_in    = 1'b1;
      end
    end else if (r_state != S_IDLE && w_enable) begin
      if (r_pend_valid) w_drop    = 1'b1;
      else              w_capture = 1'b1;
    end
`else
    w_drop = (r_state != S_IDLE) && w_enable;
`endif
    if (CLEAR) w_state_next = S_IDLE;
  end

  // Saturating update of the requested entry.
  assign w_req_valid = ({1'b0, r_req_id} < 5'(NUM_PRODUCTS));
  assign w_tgt_qty   = w_req_valid ? r_qty[r_req_id] : '0;
  assign w_sum_ext   = {1'b0, w_tgt_qty} + (QTY_W+1)'(r_req_qty);
  assign w_new_qty   = r_req_remove
                       ? ((w_tgt_qty > QTY_W'(r_req_qty)) ? w_tgt_qty - QTY_W'(r_req_qty) : '0)
                       : (w_sum_ext[QTY_W] ? '1 : w_sum_ext[QTY_W-1:0]);

  // One table entry per SUM cycle.
  assign w_cur_qty  = ({1'b0, r_idx} < 5'(NUM_PRODUCTS)) ? r_qty[r_idx] : '0;
  assign w_price    = TOTAL_W'(PRICE_BASE) + TOTAL_W'(r_idx) * TOTAL_W'(PRICE_STEP);
  assign w_acc_next = r_acc + TOTAL_W'(w_cur_qty) * w_price;
  assign w_cnt_next = r_cnt + {3'b000, (w_cur_qty != '0)};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) r_qty[i] <= '0;
      r_req_id      <= '0;
      r_req_qty     <= '0;
      r_req_remove  <= 1'b0;
      r_idx         <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      RD_QTY        <= '0;
      Total_out     <= '0;
      ItemCount_out <= '0;
      Invalid_Flag  <= 1'b0;
      Drop_Flag     <= 1'b0;
`ifdef BASKET_PENDING_EN
      r_pend_valid  <= 1'b0;
      r_pend_id     <= '0;
      r_pend_qty    <= '0;
      r_pend_remove <= 1'b0;
`endif
    end else if (CLEAR) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) r_qty[i] <= '0;
      RD_QTY        <= '0;
      Total_out     <= '0;
      ItemCount_out <= '0;
`ifdef BASKET_PENDING_EN
      r_pend_valid  <= 1'b0;
`endif
    end else begin
      if (w_load_in) begin
        r_req_id     <= ProductID_in;
        r_req_qty    <= ProductQuantity_in;
        r_req_remove <= Remove_in;
      end
`ifdef BASKET_PENDING_EN
      if (w_load_pend) begin
        r_req_id     <= r_pend_id;
        r_req_qty    <= r_pend_qty;
        r_req_remove <= r_pend_remove;
        r_pend_valid <= 1'b0;
      end
      if (w_capture) begin
        r_pend_id     <= ProductID_in;
        r_pend_qty    <= ProductQuantity_in;
        r_pend_remove <= Remove_in;
        r_pend_valid  <= 1'b1;
      end
`endif
      if (w_drop) Drop_Flag <= 1'b1;
      if (r_state == S_UPDATE) begin
        r_idx <= '0;
        r_acc <= '0;
        r_cnt <= '0;
        if (!w_req_valid)          Invalid_Flag      <= 1'b1;
        else if (r_req_qty != '0) r_qty[r_req_id]   <= w_new_qty;
      end
      if (r_state == S_SUM) begin
        r_idx <= r_idx + 4'd1;
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        if (w_last) begin
          Total_out     <= w_acc_next;
          ItemCount_out <= w_cnt_next;
        end
      end
      RD_QTY <= ({1'b0, RD_ADDR} < 5'(NUM_PRODUCTS)) ? r_qty[RD_ADDR] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_basket_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_basket_controller: self-checking bench for basket_controller.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_basket_controller;

  localparam int NUM_PRODUCTS = 12;
  localparam int QTY_MAX      = 255;
  localparam int LATENCY      = NUM_PRODUCTS + 2;

  logic        CLK = 1'b0;
  logic        RESET_N, ENABLE, Remove_in, CLEAR;
  logic [3:0]  ProductID_in, ProductQuantity_in, RD_ADDR;
  logic [7:0]  RD_QTY;
  logic [19:0] Total_out;
  logic [3:0]  ItemCount_out;
  logic        Busy, Done_Pulse, Invalid_Flag, Drop_Flag;

  int checks = 0;
  int errors = 0;
  int model_qty [NUM_PRODUCTS];
  bit exp_invalid = 1'b0;
  bit exp_drop    = 1'b0;

  always #5 CLK = ~CLK;

  basket_controller dut (
    .CLK                (CLK),
    .RESET_N            (RESET_N),
    .ENABLE             (ENABLE),
    .ProductID_in       (ProductID_in),
    .ProductQuantity_in (ProductQuantity_in),
    .Remove_in          (Remove_in),
    .CLEAR              (CLEAR),
    .RD_ADDR            (RD_ADDR),
    .RD_QTY             (RD_QTY),
    .Total_out          (Total_out),
    .ItemCount_out      (ItemCount_out),
    .Busy               (Busy),
    .Done_Pulse         (Done_Pulse),
    .Invalid_Flag       (Invalid_Flag),
    .Drop_Flag          (Drop_Flag)
  );

  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < NUM_PRODUCTS; i++) t += model_qty[i] * (5 + 5 * i);
    return t;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NUM_PRODUCTS; i++) if (model_qty[i] != 0) n++;
    return n;
  endfunction

  function automatic void model_apply(input int id, input int q, input bit rem);
    if (id >= NUM_PRODUCTS) exp_invalid = 1'b1;
    else if (rem)           model_qty[id] = (model_qty[id] > q) ? model_qty[id] - q : 0;
    else                    model_qty[id] = (model_qty[id] + q > QTY_MAX) ? QTY_MAX : model_qty[id] + q;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_PRODUCTS; i++) model_qty[i] = 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input int id, input int q, input bit rem);
    ENABLE             = 1'b1;
    ProductID_in       = 4'(id);
    ProductQuantity_in = 4'(q);
    Remove_in          = rem;
    tick();
    ENABLE = 1'b0;
  endtask

  task automatic run_request(input int id, input int q, input bit rem);
    int cyc;
    issue(id, q, rem);
    check("busy_after_enable", 32'(Busy), 1);
    cyc = 1;
    while (!Done_Pulse && cyc < 40) begin
      tick();
      cyc++;
    end
    check("done_latency", cyc, LATENCY);
    model_apply(id, q, rem);
    check("total", 32'(Total_out), model_total());
    check("item_count", 32'(ItemCount_out), model_count());
    check("invalid_flag", 32'(Invalid_Flag), 32'(exp_invalid));
    check("drop_flag", 32'(Drop_Flag), 32'(exp_drop));
    tick();
    check("done_single_cycle", 32'(Done_Pulse), 0);
    check("busy_released", 32'(Busy), 0);
  endtask

  task automatic read_check(input int addr);
    RD_ADDR = 4'(addr);
    tick();
    check("rd_qty", 32'(RD_QTY), (addr < NUM_PRODUCTS) ? model_qty[addr] : 0);
  endtask

  task automatic clear_pulse();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    model_clear();
    check("clear_total", 32'(Total_out), 0);
    check("clear_count", 32'(ItemCount_out), 0);
    check("clear_busy", 32'(Busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, first_done, second_done, npulse, id, q;
    bit rem;

    RESET_N = 1'b0; ENABLE = 1'b0; CLEAR = 1'b0; Remove_in = 1'b0;
    ProductID_in = '0; ProductQuantity_in = '0; RD_ADDR = '0;
    model_clear();
    repeat (3) tick();
    check("rst_total", 32'(Total_out), 0);
    check("rst_count", 32'(ItemCount_out), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done_Pulse), 0);
    check("rst_invalid", 32'(Invalid_Flag), 0);
    check("rst_drop", 32'(Drop_Flag), 0);
    check("rst_rd_qty", 32'(RD_QTY), 0);
    RESET_N = 1'b1;
    tick();

    // Single add: 3 * price(2) = 45
    run_request(2, 3, 1'b0);
    read_check(2);
    check("first_total_45", 32'(Total_out), 45);

    // Saturation at QTY_MAX and flooring at zero
    clear_pulse();
    for (int k = 0; k < 18; k++) run_request(11, 15, 1'b0);
    read_check(11);
    check("sat_total", 32'(Total_out), 255 * 60);
    for (int k = 0; k < 18; k++) run_request(11, 15, 1'b1);
    read_check(11);
    check("floor_total", 32'(Total_out), 0);
    check("floor_count", 32'(ItemCount_out), 0);

    // Out-of-range ID
    run_request(4, 2, 1'b0);
    run_request(13, 5, 1'b0);
    check("invalid_set", 32'(Invalid_Flag), 1);
    read_check(4);

    // Second request three cycles after the first
    issue(0, 1, 1'b0);
    tick();
    tick();
    issue(1, 2, 1'b0);
    c = 4; first_done = -1; second_done = -1; npulse = 0;
    while (c < 45) begin
      if (Done_Pulse) begin
        npulse++;
        if (first_done < 0) first_done = c;
        else                second_done = c;
      end
      tick();
      c++;
    end
    model_apply(0, 1, 1'b0);
    check("b2b_first_done_cycle", first_done, LATENCY);
`ifdef BASKET_PENDING_EN
    model_apply(1, 2, 1'b0);
    check("b2b_pulses", npulse, 2);
    check("b2b_second_done_cycle", second_done, 2 * LATENCY);
`else
    exp_drop = 1'b1;
    check("b2b_pulses", npulse, 1);
`endif
    check("b2b_drop", 32'(Drop_Flag), 32'(exp_drop));
    check("b2b_total", 32'(Total_out), model_total());
    check("b2b_count", 32'(ItemCount_out), model_count());
    check("b2b_idle", 32'(Busy), 0);

    // CLEAR during SUM with a basket worth 100
    clear_pulse();
    run_request(3, 5, 1'b0);
    check("pre_clear_total", 32'(Total_out), 100);
    issue(0, 1, 1'b0);
    repeat (6) tick();
    check("sum_holds_total", 32'(Total_out), 100);
    check("sum_busy", 32'(Busy), 1);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    model_clear();
    check("midsum_clear_busy", 32'(Busy), 0);
    check("midsum_clear_total", 32'(Total_out), 0);
    check("midsum_clear_count", 32'(ItemCount_out), 0);
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      if (Done_Pulse) npulse++;
      tick();
    end
    check("midsum_clear_no_done", npulse, 0);
    for (int a = 0; a < 16; a++) read_check(a);

    // CLEAR and ENABLE together: request discarded, not counted as dropped
    ENABLE = 1'b1; CLEAR = 1'b1; ProductID_in = 4'd4; ProductQuantity_in = 4'd2; Remove_in = 1'b0;
    tick();
    ENABLE = 1'b0; CLEAR = 1'b0;
    check("clr_en_busy", 32'(Busy), 0);
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      if (Done_Pulse) npulse++;
      tick();
    end
    check("clr_en_no_done", npulse, 0);
    check("clr_en_drop", 32'(Drop_Flag), 32'(exp_drop));
    read_check(4);

    // Randomized requests against the model
    for (int k = 0; k < 24; k++) begin
      id  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
      q   = int'($urandom_range(0, 15));
      rem = ($urandom_range(0, 2) == 0);
      run_request(id, q, rem);
      read_check(int'($urandom_range(0, 15)));
    end

    // Asynchronous reset during SUM
    issue(5, 2, 1'b0);
    repeat (5) tick();
    #3;
    RESET_N = 1'b0;
    #1;
    model_clear();
    exp_invalid = 1'b0;
    exp_drop    = 1'b0;
    check("arst_total", 32'(Total_out), 0);
    check("arst_count", 32'(ItemCount_out), 0);
    check("arst_busy", 32'(Busy), 0);
    check("arst_done", 32'(Done_Pulse), 0);
    check("arst_invalid", 32'(Invalid_Flag), 0);
    check("arst_drop", 32'(Drop_Flag), 0);
    check("arst_rd_qty", 32'(RD_QTY), 0);
    #2;
    RESET_N = 1'b1;
    tick();
    run_request(6, 4, 1'b0);
    check("post_reset_total", 32'(Total_out), 140);
    read_check(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
